// File: rtl/load_return_buffer_pkg.sv
// rtl/load_return_buffer_pkg.sv - shared types and constants for the load return buffer
// Purpose: load size/sign/op encodings, buffer entry record and default depth.
package load_return_buffer_pkg;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2
  } msize_t;

  typedef enum logic {
    UNSIGNED = 1'b0,
    SIGNED   = 1'b1
  } sign_t;

  typedef enum logic [1:0] {
    OP_OTHER = 2'd0,
    OP_LWL   = 2'd1,
    OP_LWR   = 2'd2
  } op_t;

  localparam int LRB_DEPTH = 4;

  // Offset is held at the widest legal width (64-bit bus); narrower buses
  // leave the top bit at zero.
  typedef struct packed {
    logic [2:0]  off;
    msize_t      msize;
    sign_t       sig;
    op_t         op;
    logic [31:0] ref_val;
    logic        filled;
    logic        killed;
    logic [31:0] result;
    logic        misalign;
  } lrb_entry_t;

endpackage

// File: rtl/load_return_buffer_if.sv
// rtl/load_return_buffer_if.sv - issue, bus-response and writeback handshake bundle
// Purpose: groups the load buffer handshakes into one port.
// Signals: req_* load issue (valid/ready + metadata), resp_* bus data (no stall),
//          out_* formatted result (valid/ready).
interface load_return_buffer_if
  import load_return_buffer_pkg::*;
#(
  parameter int BUS_W = 32
);
  localparam int OFF_W = $clog2(BUS_W / 8);

  logic              req_valid;
  logic              req_ready;
  logic [OFF_W-1:0]  req_off;
  msize_t            req_msize;
  sign_t             req_sig;
  op_t               req_op;
  logic [31:0]       req_ref;

  logic              resp_valid;
  logic [BUS_W-1:0]  resp_data;

  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic              out_misalign;

  modport master (
    output req_valid, req_off, req_msize, req_sig, req_op, req_ref,
    output resp_valid, resp_data, out_ready,
    input  req_ready, out_valid, out_data, out_misalign
  );

  modport slave (
    input  req_valid, req_off, req_msize, req_sig, req_op, req_ref,
    input  resp_valid, resp_data, out_ready,
    output req_ready, out_valid, out_data, out_misalign
  );

endinterface

// File: rtl/load_return_buffer_load_format.sv
// rtl/load_return_buffer_load_format.sv - combinational lane select, extend and LWL/LWR merge
// Purpose: turns one raw bus response into the 32-bit load result.
// Ports: resp_word (raw bus data), off/msize/sig/op/ref_val (load metadata) in;
//        result (formatted word) and misalign out.
module load_format
  import load_return_buffer_pkg::*;
#(
  parameter int BUS_W = 32
) (
  input  logic [BUS_W-1:0] resp_word,
  input  logic [2:0]       off,
  input  msize_t           msize,
  input  sign_t            sig,
  input  op_t              op,
  input  logic [31:0]      ref_val,
  output logic [31:0]      result,
  output logic             misalign
);

  logic [31:0] b;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    // 64-bit bus: off[2] picks the upper word, then 32-bit rules apply.
    b = resp_word[31:0];
    if ((BUS_W == 64) && off[2]) begin
      b = resp_word[BUS_W-1 -: 32];
    end

    case (off[1:0])
      2'd0:    byte_v = b[7:0];
      2'd1:    byte_v = b[15:8];
      2'd2:    byte_v = b[23:16];
      default: byte_v = b[31:24];
    endcase
    half_v = off[1] ? b[31:16] : b[15:0];

    result   = '0;
    misalign = 1'b0;
    case (msize)
      MSIZE1: result = (sig == SIGNED) ? {{24{byte_v[7]}}, byte_v} : {24'd0, byte_v};
      MSIZE2: begin
        if (off[0]) begin
          misalign = 1'b1;
        end else begin
          result = (sig == SIGNED) ? {{16{half_v[15]}}, half_v} : {16'd0, half_v};
        end
      end
      MSIZE4: begin
        case (op)
          OP_LWL: begin
            case (off[1:0])
              2'd0:    result = {b[7:0],  ref_val[23:0]};
              2'd1:    result = {b[15:0], ref_val[15:0]};
              2'd2:    result = {b[23:0], ref_val[7:0]};
              default: result = b;
            endcase
          end
          OP_LWR: begin
            case (off[1:0])
              2'd0:    result = b;
              2'd1:    result = {ref_val[31:24], b[31:8]};
              2'd2:    result = {ref_val[31:16], b[31:16]};
              default: result = {ref_val[31:8],  b[31:24]};
            endcase
          end
          default: begin
            if (off[1:0] != 2'd0) begin
              misalign = 1'b1;
            end else begin
              result = b;
            end
          end
        endcase
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/load_return_buffer.sv
// rtl/load_return_buffer.sv - in-order load completion buffer between bus response and writeback
// Purpose: records load metadata at issue, formats the bus response on arrival and
//          returns results in issue order with flush/kill and orphan detection.
// Ports: clk, reset (async, active-high); bus (load_return_buffer_if.slave: req/resp/out
//        handshakes); flush (kill all allocated loads); pending (allocated entry count);
//        orphan_err (sticky: response arrived with no unfilled entry).
module load_return_buffer
  import load_return_buffer_pkg::*;
#(
  parameter int BUS_W = 32,
  parameter int DEPTH = LRB_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  load_return_buffer_if.slave     bus,
  input  logic                    flush,
  output logic [$clog2(DEPTH):0]  pending,
  output logic                    orphan_err
);

  localparam int PW = $clog2(DEPTH);
  typedef logic [PW:0]   ptr_t;
  typedef logic [PW-1:0] idx_t;

  lrb_entry_t entries_q [DEPTH];
  lrb_entry_t entries_d [DEPTH];
  ptr_t alloc_ptr_q, alloc_ptr_d;
  ptr_t fill_ptr_q,  fill_ptr_d;
  ptr_t head_ptr_q,  head_ptr_d;
  logic orphan_err_q, orphan_err_d;

  idx_t alloc_idx, fill_idx, head_idx, rel_idx;
  logic head_busy, head_filled, head_killed;
  logic req_ready_w, out_valid_w;
  logic do_pop, do_alloc, do_fill, resp_orphan;
  logic [31:0] fmt_result;
  logic        fmt_misalign;

  assign alloc_idx   = alloc_ptr_q[PW-1:0];
  assign fill_idx    = fill_ptr_q[PW-1:0];
  assign head_idx    = head_ptr_q[PW-1:0];

  assign pending     = alloc_ptr_q - head_ptr_q;
  assign head_busy   = (head_ptr_q != alloc_ptr_q);
  assign head_filled = entries_q[head_idx].filled;
  assign head_killed = entries_q[head_idx].killed;

  // No bypass: a slot freed by this cycle's pop is only offered next cycle.
  assign req_ready_w = (pending != ptr_t'(DEPTH)) && !flush;
  assign out_valid_w = head_busy && head_filled && !head_killed;

  assign bus.req_ready    = req_ready_w;
  assign bus.out_valid    = out_valid_w;
  assign bus.out_data     = out_valid_w ? entries_q[head_idx].result : '0;
  assign bus.out_misalign = out_valid_w && entries_q[head_idx].misalign;

  // Killed entries drain silently once their response has been absorbed.
  assign do_pop      = head_busy && head_filled && (head_killed || bus.out_ready);
  assign do_alloc    = bus.req_valid && req_ready_w;
  // Compared against the pre-allocation pointer, so a response to a load
  // allocated in this same cycle counts as an orphan.
  assign resp_orphan = bus.resp_valid && (fill_ptr_q == alloc_ptr_q);
  assign do_fill     = bus.resp_valid && !resp_orphan;
  assign orphan_err  = orphan_err_q;

  load_format #(.BUS_W(BUS_W)) u_load_format (
    .resp_word (bus.resp_data),
    .off       (entries_q[fill_idx].off),
    .msize     (entries_q[fill_idx].msize),
    .sig       (entries_q[fill_idx].sig),
    .op        (entries_q[fill_idx].op),
    .ref_val   (entries_q[fill_idx].ref_val),
    .result    (fmt_result),
    .misalign  (fmt_misalign)
  );

  always_comb begin
    entries_d    = entries_q;
    alloc_ptr_d  = alloc_ptr_q;
    fill_ptr_d   = fill_ptr_q;
    head_ptr_d   = head_ptr_q;
    orphan_err_d = orphan_err_q | resp_orphan;
    rel_idx      = '0;

    // Kill every live entry except a head that completes its pop this cycle.
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        rel_idx = idx_t'(i) - head_idx;
        if (({1'b0, rel_idx} < pending) && !(do_pop && (rel_idx == '0))) begin
          entries_d[i].killed = 1'b1;
        end
      end
    end

    if (do_fill) begin
      entries_d[fill_idx].filled   = 1'b1;
      entries_d[fill_idx].result   = fmt_result;
      entries_d[fill_idx].misalign = fmt_misalign;
      fill_ptr_d = fill_ptr_q + ptr_t'(1);
    end

    if (do_pop) begin
      head_ptr_d = head_ptr_q + ptr_t'(1);
    end

    if (do_alloc) begin
      entries_d[alloc_idx].off      = 3'(bus.req_off);
      entries_d[alloc_idx].msize    = bus.req_msize;
      entries_d[alloc_idx].sig      = bus.req_sig;
      entries_d[alloc_idx].op       = bus.req_op;
      entries_d[alloc_idx].ref_val  = bus.req_ref;
      entries_d[alloc_idx].filled   = 1'b0;
      entries_d[alloc_idx].killed   = 1'b0;
      entries_d[alloc_idx].result   = '0;
      entries_d[alloc_idx].misalign = 1'b0;
      alloc_ptr_d = alloc_ptr_q + ptr_t'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      alloc_ptr_q  <= '0;
      fill_ptr_q   <= '0;
      head_ptr_q   <= '0;
      orphan_err_q <= 1'b0;
    end else begin
      entries_q    <= entries_d;
      alloc_ptr_q  <= alloc_ptr_d;
      fill_ptr_q   <= fill_ptr_d;
      head_ptr_q   <= head_ptr_d;
      orphan_err_q <= orphan_err_d;
    end
  end

endmodule

// File: tb/tb_load_return_buffer.sv
// tb/tb_load_return_buffer.sv - self-checking bench for load_return_buffer (32- and 64-bit bus)
module tb_load_return_buffer;
  import load_return_buffer_pkg::*;

  localparam int DEPTH = 4;
  localparam int NV = 11;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        req_valid;
  logic [2:0]  req_off3;
  msize_t      req_msize;
  sign_t       req_sig;
  op_t         req_op;
  logic [31:0] req_ref;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        out_ready;
  logic [2:0]  pend32, pend64;
  logic        orph32, orph64;

  int checks = 0;
  int failures = 0;

  load_return_buffer_if #(.BUS_W(32)) i32 ();
  load_return_buffer_if #(.BUS_W(64)) i64 ();

  assign i32.req_valid  = req_valid;
  assign i32.req_off    = req_off3[1:0];
  assign i32.req_msize  = req_msize;
  assign i32.req_sig    = req_sig;
  assign i32.req_op     = req_op;
  assign i32.req_ref    = req_ref;
  assign i32.resp_valid = resp_valid;
  assign i32.resp_data  = resp_data[31:0];
  assign i32.out_ready  = out_ready;

  assign i64.req_valid  = req_valid;
  assign i64.req_off    = req_off3;
  assign i64.req_msize  = req_msize;
  assign i64.req_sig    = req_sig;
  assign i64.req_op     = req_op;
  assign i64.req_ref    = req_ref;
  assign i64.resp_valid = resp_valid;
  assign i64.resp_data  = resp_data;
  assign i64.out_ready  = out_ready;

  load_return_buffer #(.BUS_W(32), .DEPTH(DEPTH)) dut32 (
    .clk(clk), .reset(reset), .bus(i32.slave), .flush(flush),
    .pending(pend32), .orphan_err(orph32)
  );

  load_return_buffer #(.BUS_W(64), .DEPTH(DEPTH)) dut64 (
    .clk(clk), .reset(reset), .bus(i64.slave), .flush(flush),
    .pending(pend64), .orphan_err(orph64)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (actual=timeout required=finish)");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  off;
    int          msz;
    bit          sgn;
    int          op;
    logic [31:0] rf;
    logic [63:0] d;
    logic [31:0] e32;
    logic        m32;
    logic [31:0] e64;
    logic        m64;
  } vec_t;

  typedef struct {
    logic [2:0]  off;
    int          msz;
    bit          sgn;
    int          op;
    logic [31:0] rf;
    bit          filled;
    bit          killed;
    logic [31:0] r32;
    logic        m32;
    logic [31:0] r64;
    logic        m64;
  } ment_t;

  vec_t  vt [NV];
  ment_t mq [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic set_idle();
    req_valid  = 1'b0;
    req_off3   = 3'd0;
    req_msize  = MSIZE4;
    req_sig    = UNSIGNED;
    req_op     = OP_OTHER;
    req_ref    = 32'd0;
    resp_valid = 1'b0;
    resp_data  = 64'd0;
    flush      = 1'b0;
  endtask

  task automatic do_reset();
    set_idle();
    out_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Reference formatting from byte arithmetic (shift/mask), independent of lane tables.
  function automatic void fmt(input logic [63:0] d, input bit wide, input logic [2:0] off3,
                              input int msz, input bit sgn, input int op, input logic [31:0] rf,
                              output logic [31:0] res, output logic mis);
    logic [63:0] w;
    logic [63:0] t;
    int o;
    o = int'(off3[1:0]);
    w = (wide && off3[2]) ? {32'd0, d[63:32]} : {32'd0, d[31:0]};
    res = 32'd0;
    mis = 1'b0;
    t = 64'd0;
    if (msz == 0) begin
      t = (w >> (8 * o)) & 64'hFF;
      if (sgn && t[7]) t = t | 64'hFFFFFF00;
      res = t[31:0];
    end else if (msz == 1) begin
      if ((o % 2) == 1) mis = 1'b1;
      else begin
        t = (w >> (8 * o)) & 64'hFFFF;
        if (sgn && t[15]) t = t | 64'hFFFF0000;
        res = t[31:0];
      end
    end else if (op == 1) begin
      t = (w << (8 * (3 - o))) | ({32'd0, rf} & (64'hFFFFFFFF >> (8 * (o + 1))));
      res = t[31:0];
    end else if (op == 2) begin
      t = (w >> (8 * o)) | ({32'd0, rf} & ~(64'hFFFFFFFF >> (8 * o)));
      res = t[31:0];
    end else if (o != 0) begin
      mis = 1'b1;
    end else begin
      res = w[31:0];
    end
  endfunction

  task automatic drive_req(input logic [2:0] off, input int msz, input bit sgn,
                           input int op, input logic [31:0] rf);
    req_valid = 1'b1;
    req_off3  = off;
    req_msize = msize_t'(msz);
    req_sig   = sign_t'(sgn);
    req_op    = op_t'(op);
    req_ref   = rf;
  endtask

  task automatic single_load(input vec_t v, input string tag);
    set_idle();
    out_ready = 1'b1;
    drive_req(v.off, v.msz, v.sgn, v.op, v.rf);
    #1;
    chk1({tag, "_req_ready"}, i32.req_ready & i64.req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    tick();
    resp_valid = 1'b1;
    resp_data  = v.d;
    #1;
    chk1({tag, "_no_same_cycle"}, i32.out_valid | i64.out_valid, 1'b0);
    tick();
    resp_valid = 1'b0;
    #1;
    chk1 ({tag, "_valid32"}, i32.out_valid, 1'b1);
    chk32({tag, "_data32"},  i32.out_data, v.e32);
    chk1 ({tag, "_mis32"},   i32.out_misalign, v.m32);
    chk1 ({tag, "_valid64"}, i64.out_valid, 1'b1);
    chk32({tag, "_data64"},  i64.out_data, v.e64);
    chk1 ({tag, "_mis64"},   i64.out_misalign, v.m64);
    tick();
    #1;
    chk32({tag, "_pending_after"}, {29'd0, pend32 | pend64}, 32'd0);
  endtask

  initial begin
    logic saw;
    int nf;
    bit draining;
    bit exp_ready;
    bit exp_valid;
    bit pop_m;
    bit fill_m;
    bit alloc_m;

    vt[0]  = '{3'd3, 0, 1'b1, 0, 32'h0,        64'h0000_0000_8011_2233, 32'hFFFFFF80, 1'b0, 32'hFFFFFF80, 1'b0};
    vt[1]  = '{3'd6, 1, 1'b0, 0, 32'h0,        64'hBEEF_0000_0000_0000, 32'h00000000, 1'b0, 32'h0000BEEF, 1'b0};
    vt[2]  = '{3'd1, 2, 1'b0, 1, 32'hAABBCCDD, 64'h0000_0000_1122_3344, 32'h3344CCDD, 1'b0, 32'h3344CCDD, 1'b0};
    vt[3]  = '{3'd2, 2, 1'b0, 2, 32'hAABBCCDD, 64'h0000_0000_1122_3344, 32'hAABB1122, 1'b0, 32'hAABB1122, 1'b0};
    vt[4]  = '{3'd2, 2, 1'b0, 0, 32'h0,        64'h0000_0000_1122_3344, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
    vt[5]  = '{3'd1, 0, 1'b0, 0, 32'h0,        64'h0000_0000_0000_F100, 32'h000000F1, 1'b0, 32'h000000F1, 1'b0};
    vt[6]  = '{3'd4, 1, 1'b1, 0, 32'h0,        64'h0000_8001_1234_5678, 32'h00005678, 1'b0, 32'hFFFF8001, 1'b0};
    vt[7]  = '{3'd1, 1, 1'b0, 0, 32'h0,        64'h0000_0000_1234_5678, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
    vt[8]  = '{3'd4, 2, 1'b0, 0, 32'h0,        64'hCAFE_F00D_1234_5678, 32'h12345678, 1'b0, 32'hCAFEF00D, 1'b0};
    vt[9]  = '{3'd3, 2, 1'b0, 2, 32'hAABBCCDD, 64'h0000_0000_1122_3344, 32'hAABBCC11, 1'b0, 32'hAABBCC11, 1'b0};
    vt[10] = '{3'd0, 2, 1'b0, 1, 32'hAABBCCDD, 64'h0000_0000_1122_3344, 32'h44BBCCDD, 1'b0, 32'h44BBCCDD, 1'b0};

    // Reset state
    do_reset();
    #1;
    chk32("rst_pending32", {29'd0, pend32}, 32'd0);
    chk32("rst_pending64", {29'd0, pend64}, 32'd0);
    chk1 ("rst_out_valid", i32.out_valid | i64.out_valid, 1'b0);
    chk32("rst_out_data",  i32.out_data | i64.out_data, 32'd0);
    chk1 ("rst_misalign",  i32.out_misalign | i64.out_misalign, 1'b0);
    chk1 ("rst_orphan",    orph32 | orph64, 1'b0);
    chk1 ("rst_req_ready", i32.req_ready & i64.req_ready, 1'b1);

    // Table of single loads
    for (int k = 0; k < NV; k++) begin
      single_load(vt[k], $sformatf("tbl%0d", k));
    end

    // LWL then LWR back-to-back, results in issue order
    set_idle();
    out_ready = 1'b1;
    drive_req(3'd1, 2, 1'b0, 1, 32'hAABBCCDD);
    tick();
    drive_req(3'd2, 2, 1'b0, 2, 32'hAABBCCDD);
    tick();
    req_valid  = 1'b0;
    resp_valid = 1'b1;
    resp_data  = 64'h0000_0000_1122_3344;
    tick();
    #1;
    chk1 ("b2b_first_valid", i32.out_valid, 1'b1);
    chk32("b2b_first_lwl",   i32.out_data, 32'h3344CCDD);
    tick();
    resp_valid = 1'b0;
    #1;
    chk1 ("b2b_second_valid", i64.out_valid, 1'b1);
    chk32("b2b_second_lwr",   i64.out_data, 32'hAABB1122);
    tick();

    // Fill to DEPTH with writeback stalled, then drain one per cycle
    set_idle();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive_req(3'd0, 2, 1'b0, 0, 32'h0);
      #1;
      chk1($sformatf("full_ready_%0d", i), i32.req_ready, 1'b1);
      tick();
    end
    #1;
    chk32("full_pending", {29'd0, pend32}, DEPTH);
    chk1 ("full_not_ready", i32.req_ready | i64.req_ready, 1'b0);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      resp_valid = 1'b1;
      resp_data  = {32'hDEAD_0000, 32'h1000 + 32'(i)};
      tick();
    end
    resp_valid = 1'b0;
    #1;
    chk32("full_pending_held", {29'd0, pend64}, DEPTH);
    chk1 ("full_stall_valid", i32.out_valid, 1'b1);
    chk32("full_stall_data",  i32.out_data, 32'h1000);
    tick();
    out_ready = 1'b1;
    #1;
    chk1("full_pop_cycle_not_ready", i32.req_ready, 1'b0);
    chk32("full_pop0_data", i64.out_data, 32'h1000);
    tick();
    #1;
    chk1("full_ready_after_pop", i32.req_ready & i64.req_ready, 1'b1);
    for (int i = 1; i < DEPTH; i++) begin
      chk1 ($sformatf("full_pop%0d_valid", i), i32.out_valid, 1'b1);
      chk32($sformatf("full_pop%0d_data", i), i32.out_data, 32'h1000 + 32'(i));
      tick();
      #1;
    end
    chk32("full_drained", {29'd0, pend32}, 32'd0);

    // Flush before either response
    set_idle();
    out_ready = 1'b1;
    drive_req(3'd0, 2, 1'b0, 0, 32'h0);
    tick();
    tick();
    req_valid = 1'b0;
    flush = 1'b1;
    #1;
    chk1 ("flush_blocks_req", i32.req_ready, 1'b0);
    chk32("flush_pending", {29'd0, pend32}, 32'd2);
    tick();
    flush = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 2; i++) begin
      resp_valid = 1'b1;
      resp_data  = 64'h5555_5555_5555_5555;
      #1;
      saw = saw | i32.out_valid | i64.out_valid;
      tick();
    end
    resp_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      saw = saw | i32.out_valid | i64.out_valid;
      if (pend32 == 3'd0 && pend64 == 3'd0) break;
      tick();
    end
    chk1 ("flush_never_valid", saw, 1'b0);
    chk32("flush_pending_zero", {29'd0, pend32 | pend64}, 32'd0);
    chk1 ("flush_no_orphan", orph32 | orph64, 1'b0);
    single_load(vt[0], "after_flush");

    // Orphan response, sticky until reset
    set_idle();
    #1;
    chk1("orphan_clear_before", orph32, 1'b0);
    resp_valid = 1'b1;
    resp_data  = 64'h1;
    tick();
    resp_valid = 1'b0;
    #1;
    chk1("orphan_set32", orph32, 1'b1);
    chk1("orphan_set64", orph64, 1'b1);
    tick();
    tick();
    tick();
    #1;
    chk1 ("orphan_sticky", orph32 & orph64, 1'b1);
    chk32("orphan_no_entry", {29'd0, pend32}, 32'd0);
    do_reset();
    #1;
    chk1("orphan_cleared_by_reset", orph32 | orph64, 1'b0);

    // Randomised traffic against the queue model
    mq.delete();
    for (int cyc = 0; cyc < 500; cyc++) begin
      draining = (cyc >= 440);
      nf = 0;
      foreach (mq[i]) if (mq[i].filled) nf++;
      req_valid  = !draining && ($urandom_range(1, 0) == 1);
      req_off3   = 3'($urandom_range(7, 0));
      req_msize  = msize_t'($urandom_range(2, 0));
      req_sig    = sign_t'($urandom_range(1, 0));
      req_op     = op_t'($urandom_range(2, 0));
      req_ref    = $urandom;
      resp_valid = (nf < mq.size()) && (draining || ($urandom_range(1, 0) == 0));
      resp_data  = {$urandom, $urandom};
      flush      = !draining && ($urandom_range(15, 0) == 0);
      out_ready  = draining || ($urandom_range(3, 0) != 0);
      #1;

      exp_ready = (mq.size() < DEPTH) && !flush;
      exp_valid = (mq.size() > 0) && mq[0].filled && !mq[0].killed;
      chk32($sformatf("rnd%0d_pending32", cyc), {29'd0, pend32}, mq.size());
      chk32($sformatf("rnd%0d_pending64", cyc), {29'd0, pend64}, mq.size());
      chk1 ($sformatf("rnd%0d_req_ready", cyc), i32.req_ready & i64.req_ready, exp_ready);
      chk1 ($sformatf("rnd%0d_valid32", cyc), i32.out_valid, exp_valid);
      chk1 ($sformatf("rnd%0d_valid64", cyc), i64.out_valid, exp_valid);
      if (exp_valid) begin
        chk32($sformatf("rnd%0d_data32", cyc), i32.out_data, mq[0].r32);
        chk1 ($sformatf("rnd%0d_mis32", cyc),  i32.out_misalign, mq[0].m32);
        chk32($sformatf("rnd%0d_data64", cyc), i64.out_data, mq[0].r64);
        chk1 ($sformatf("rnd%0d_mis64", cyc),  i64.out_misalign, mq[0].m64);
      end

      pop_m   = (mq.size() > 0) && mq[0].filled && (mq[0].killed || out_ready);
      fill_m  = resp_valid && (nf < mq.size());
      alloc_m = req_valid && exp_ready;
      if (fill_m) begin
        fmt(resp_data, 1'b0, mq[nf].off, mq[nf].msz, mq[nf].sgn, mq[nf].op, mq[nf].rf,
            mq[nf].r32, mq[nf].m32);
        fmt(resp_data, 1'b1, mq[nf].off, mq[nf].msz, mq[nf].sgn, mq[nf].op, mq[nf].rf,
            mq[nf].r64, mq[nf].m64);
        mq[nf].filled = 1'b1;
      end
      if (flush) begin
        for (int i = (pop_m ? 1 : 0); i < mq.size(); i++) mq[i].killed = 1'b1;
      end
      if (pop_m) void'(mq.pop_front());
      if (alloc_m) begin
        mq.push_back('{req_off3, int'(req_msize), bit'(req_sig), int'(req_op), req_ref,
                       1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0});
      end
      tick();
    end
    set_idle();
    #1;
    chk32("rnd_final_pending", {29'd0, pend32 | pend64}, mq.size());
    chk1 ("rnd_no_orphan", orph32 | orph64, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_return_buffer.md
Name: load_return_buffer

Overview:
- In-order completion buffer between the data-bus response and the memory-stage writeback.
- Records each load's formatting metadata at issue and captures the bus response when it arrives, at any later cycle.
- Produces the extended, lane-selected or merged 32-bit result with a valid/ready handshake.
- Generalises the single-cycle load-data selector to parametrised bus width, multiple outstanding loads, flush/kill, and misalignment flagging.

Parameters:
- BUS_W, 32, data-bus width in bits; legal values 32 or 64.
- DEPTH, 4, maximum outstanding plus unretired loads; power of two, at least 2.
- OFF_W, $clog2(BUS_W/8), address offset bits; derived, not overridable.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- req_valid  in  1  load issued to bus this cycle
- req_ready  out  1  entry available
- req_off  in  OFF_W  addr[OFF_W-1:0] of the load
- req_msize  in  msize_t  MSIZE1/MSIZE2/MSIZE4
- req_sig  in  1  UNSIGNED/SIGNED
- req_op  in  op_t  LWL/LWR/other
- req_ref  in  32  old rt value for LWL/LWR merge
- resp_valid  in  1  bus data_ok; cannot be stalled
- resp_data  in  BUS_W  raw bus data
- flush  in  1  kill all allocated loads
- out_valid  out  1  head result ready
- out_ready  in  1  writeback accepts
- out_data  out  32  formatted result
- out_misalign  out  1  head load was misaligned
- pending  out  $clog2(DEPTH)+1  allocated entry count
- orphan_err  out  1  sticky: response with no unfilled entry

Behaviour:
- Reset (async, active-high): all pointers 0, all entries invalid, pending=0, out_valid=0, out_data=0, out_misalign=0, orphan_err=0. Reset mid-operation discards everything.
- Circular storage of DEPTH entries; each entry holds off, msize, sig, op, ref, filled, killed, result, misalign.
- Three pointers, each one extra wrap bit wide: alloc_ptr, fill_ptr, head_ptr.
- pending = alloc_ptr - head_ptr.
- req_ready = (pending < DEPTH) && !flush. There is no bypass from a same-cycle pop.
- Allocate: on req_valid && req_ready, write metadata at alloc_ptr; filled=0, killed=0; alloc_ptr++.
- Fill: on resp_valid, target is fill_ptr.
  - If fill_ptr == alloc_ptr, set orphan_err and drop the data.
  - Otherwise compute result and misalign combinationally from resp_data and the entry metadata, store them, set filled=1, fill_ptr++.
- Lane select:
  - BUS_W=64: choose the word by off[2] (1 selects bits 63:32).
  - Then apply the 32-bit rules using off[1:0].
- MSIZE1: byte at off[1:0], zero- or sign-extended per sig.
- MSIZE2: half at off[1]; misaligned if off[0]=1.
- MSIZE4 with LWL, by off[1:0]:
  - 0: {b[7:0], ref[23:0]}
  - 1: {b[15:0], ref[15:0]}
  - 2: {b[23:0], ref[7:0]}
  - 3: b
- MSIZE4 with LWR, by off[1:0]:
  - 0: b
  - 1: {ref[31:24], b[31:8]}
  - 2: {ref[31:16], b[31:16]}
  - 3: {ref[31:8], b[31:24]}
- MSIZE4 with any other op: misaligned if off[1:0]≠0.
- Misaligned result: result=0, misalign=1.
- Head (head_ptr != alloc_ptr and head entry filled):
  - Not killed: out_valid=1, out_data and out_misalign come from the entry registers.
  - Killed: silently popped, one per cycle, with out_valid=0.
  - Pop on out_valid && out_ready, or on killed && filled; head_ptr++.
- Latency: a response in cycle N gives out_valid in cycle N+1 when that entry is at the head. Same-cycle response-to-output is not allowed.
- out_valid stays asserted and out_data stays stable until accepted.
- Flush: in the flush cycle, set killed on every entry between head_ptr and alloc_ptr, filled or not.
  - Unfilled killed entries still consume their later responses.
  - The head entry being popped in the same cycle is not killed; the handshake completes.
- Simultaneous events: alloc, fill and pop in one cycle are all legal. Fill of an entry allocated in the same cycle is illegal (bus latency is at least 1) and is counted as orphan.
- pending, wrap: pointer wrap bit distinguishes full from empty; pending==DEPTH means full.

Decomposition:
- Shared package (mycpu):
  - msize_t, sign enum, op_t: existing.
  - New lrb_entry_t struct.
  - LRB_DEPTH default constant.
- Sub-module load_format (combinational): resp word, off, msize, sig, op, ref in; result and misalign out. Reused by the fill path.

Test Plan:
- Single LB, BUS_W=32: off=3, sig=SIGNED, resp_data=32'h80_11_22_33, response 2 cycles after issue -> out_valid one cycle after response, out_data=32'hFFFFFF80.
- BUS_W=64 LHU: off=6, resp_data=64'hBEEF_0000_0000_0000 -> out_data=32'h0000BEEF, out_misalign=0.
- LWL then LWR back-to-back:
  - LWL: ref=32'hAABBCCDD, off=1, data=32'h11223344 -> 32'h3344CCDD.
  - LWR: off=2, same data -> 32'hAABB1122.
  - Results appear in issue order.
- Fill DEPTH=4 with out_ready=0 -> req_ready=0 at pending=4. Raise out_ready -> one pop per cycle; req_ready re-asserts the cycle after the first pop.
- Two loads issued, flush before either response -> both responses are absorbed, out_valid never rises, pending returns to 0. A load issued after the flush completes normally.
- resp_valid with pending=0 -> orphan_err=1, stays set until reset. LW with off=2 -> out_data=0, out_misalign=1.
